glitc_config_ctrl: RTL and testbench



---
 rtl/glitc_config_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_glitc_config_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitc_config_ctrl.sv
// rtl/glitc_config_ctrl.sv - PROGRAM_B / INIT_B / DONE configuration sequencer for four GLITC FPGAs
module glitc_config_ctrl #(
  parameter int CNT_BITS     = 24,
  parameter int PROG_CYCLES  = 100,
  parameter int INIT_HOLD    = 100,
  parameter int INIT_TIMEOUT = 65535,
  parameter int DONE_TIMEOUT = 16777215
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic        adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic [3:0]  PROG_B,
  output logic [3:0]  INIT_B_drv,
  input  logic [3:0]  INIT_B_in,
  input  logic [3:0]  DONE,
  output logic [3:0]  gready_o
);

  // The counter reloads to 1 on state entry, so "count == limit" marks the
  // last cycle of a state that lasts exactly <limit> cycles.
  localparam logic [CNT_BITS-1:0] PROG_LIM  = CNT_BITS'(PROG_CYCLES);
  localparam logic [CNT_BITS-1:0] HOLD_LIM  = CNT_BITS'(INIT_HOLD);
  localparam logic [CNT_BITS-1:0] WINIT_LIM = CNT_BITS'(INIT_TIMEOUT);
  localparam logic [CNT_BITS-1:0] LOAD_LIM  = CNT_BITS'(DONE_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROG,
    ST_HOLD,
    ST_WINIT,
    ST_LOAD
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          tgt_q, tgt_d;
  logic [1:0]          low_idx;
  logic [3:0]          pending_q, err_q, tmo_q, gready_q;
  logic [3:0]          init_s1, init_s, done_s1, done_s;

  logic [3:0]          pend_clr, gready_set, gready_clr;
  logic [3:0]          err_set, err_clr, tmo_set, tmo_clr;
  logic [3:0]          mon_fail;
  logic [3:0]          bus_pend_set, bus_err_clr, bus_tmo_clr;
  logic                bus_acc, busy;
  logic [31:0]         ctrl_rd, status_rd;
  logic                unused_dat;

  assign busy      = (state_q != ST_IDLE);
  assign gready_o  = gready_q;
  assign unused_dat = ^dat_i[31:12];

  // A GLITC that drops DONE while marked ready loses ready and flags an error.
  assign mon_fail  = gready_q & ~done_s;

  assign bus_acc   = cyc_i & stb_i & ~ack_o;
  assign ctrl_rd   = {21'b0, tgt_q, busy, 4'b0, pending_q};
  assign status_rd = {12'b0, init_s, done_s, tmo_q, err_q, gready_q};

  assign bus_pend_set = (bus_acc & we_i & ~adr_i) ? dat_i[3:0]  : 4'h0;
  assign bus_err_clr  = (bus_acc & we_i &  adr_i) ? dat_i[7:4]  : 4'h0;
  assign bus_tmo_clr  = (bus_acc & we_i &  adr_i) ? dat_i[11:8] : 4'h0;

  // Two-flop synchronizers for the asynchronous INIT_B and DONE pins.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      init_s1 <= 4'h0;
      init_s  <= 4'h0;
      done_s1 <= 4'h0;
      done_s  <= 4'h0;
    end else begin
      init_s1 <= INIT_B_in;
      init_s  <= init_s1;
      done_s1 <= DONE;
      done_s  <= done_s1;
    end
  end

  // Register port: one ack per access, read data captured on the ack edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ack_o <= 1'b0;
      dat_o <= 32'h0;
    end else begin
      ack_o <= bus_acc;
      if (bus_acc && !we_i) begin
        dat_o <= adr_i ? status_rd : ctrl_rd;
      end
    end
  end

  // Sequencer next-state, pin drive and per-target flag set/clear requests.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    pend_clr   = 4'h0;
    gready_set = 4'h0;
    gready_clr = 4'h0;
    err_set    = 4'h0;
    err_clr    = 4'h0;
    tmo_set    = 4'h0;
    tmo_clr    = 4'h0;
    PROG_B     = 4'hF;
    INIT_B_drv = 4'h0;
    low_idx    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) low_idx = 2'(i);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q != 4'h0) begin
          tgt_d               = low_idx;
          pend_clr[low_idx]   = 1'b1;
          gready_clr[low_idx] = 1'b1;
          err_clr[low_idx]    = 1'b1;
          tmo_clr[low_idx]    = 1'b1;
          state_d             = ST_PROG;
        end
      end
      ST_PROG: begin
        PROG_B[tgt_q]     = 1'b0;
        INIT_B_drv[tgt_q] = 1'b1;
        if (cnt_q == PROG_LIM) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        INIT_B_drv[tgt_q] = 1'b1;
        if (cnt_q == HOLD_LIM) state_d = ST_WINIT;
      end
      ST_WINIT: begin
        if (init_s[tgt_q]) begin
          state_d = ST_LOAD;
        end else if (cnt_q == WINIT_LIM) begin
          tmo_set[tgt_q] = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (done_s[tgt_q]) begin
          gready_set[tgt_q] = 1'b1;
          state_d           = ST_IDLE;
        end else if (!init_s[tgt_q]) begin
          err_set[tgt_q] = 1'b1;
          state_d        = ST_IDLE;
        end else if (cnt_q == LOAD_LIM) begin
          tmo_set[tgt_q] = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = CNT_BITS'(1);
    end else if (cnt_q != {CNT_BITS{1'b1}}) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // Sequencer state and flag registers; any set beats a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tgt_q     <= 2'd0;
      pending_q <= 4'h0;
      err_q     <= 4'h0;
      tmo_q     <= 4'h0;
      gready_q  <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      pending_q <= (pending_q & ~pend_clr) | bus_pend_set;
      gready_q  <= (gready_q & ~gready_clr & ~mon_fail) | gready_set;
      err_q     <= (err_q & ~err_clr & ~bus_err_clr) | err_set | mon_fail;
      tmo_q     <= (tmo_q & ~tmo_clr & ~bus_tmo_clr) | tmo_set;
    end
  end

endmodule

// File: tb/tb_glitc_config_ctrl.sv
// tb/tb_glitc_config_ctrl.sv - randomized self-checking bench for glitc_config_ctrl
`timescale 1ns/1ps
module tb_glitc_config_ctrl;

  localparam int PROG_CYCLES  = 4;
  localparam int INIT_HOLD    = 3;
  localparam int INIT_TIMEOUT = 10;
  localparam int DONE_TIMEOUT = 200;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, adr_i = 1'b0;
  logic [31:0] dat_i = 32'h0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic [3:0]  PROG_B, INIT_B_drv, gready_o;
  logic [3:0]  INIT_B_in, DONE;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  // FPGA behaviour knobs and observations, per GLITC
  int phase[4], rel_cnt[4], init_dly[4], done_dly[4];
  bit init_stuck[4], force_init_low[4], force_done_low[4], fi[4], dn[4];
  int prog_run[4], drv_run[4], prog_len[4], drv_len[4];
  int prog_fall_cyc[4], gready_rise_cyc[4], gready_fall_cyc[4];
  int done_rise_cyc[4], done_fall_cyc[4];
  int prog_order[$];
  bit multi_viol = 1'b0;
  logic [3:0] gready_prev = 4'h0;

  glitc_config_ctrl #(
    .CNT_BITS(24), .PROG_CYCLES(PROG_CYCLES), .INIT_HOLD(INIT_HOLD),
    .INIT_TIMEOUT(INIT_TIMEOUT), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .PROG_B(PROG_B),
    .INIT_B_drv(INIT_B_drv), .INIT_B_in(INIT_B_in), .DONE(DONE), .gready_o(gready_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural FPGA pins plus pulse-width / ordering monitor, all at negedge
  initial begin
    INIT_B_in = 4'h0;
    DONE      = 4'h0;
    forever begin
      @(negedge clk_i);
      for (int n = 0; n < 4; n++) begin
        logic dnew;
        if (PROG_B[n] === 1'b0) begin
          phase[n] = 1; fi[n] = 0; dn[n] = 0;
        end else begin
          case (phase[n])
            1: if (INIT_B_drv[n] === 1'b0) begin phase[n] = 2; rel_cnt[n] = 0; end
            2: begin
              rel_cnt[n]++;
              if (!init_stuck[n] && rel_cnt[n] >= init_dly[n]) begin
                fi[n] = 1; phase[n] = 3; rel_cnt[n] = 0;
              end
            end
            3: begin
              rel_cnt[n]++;
              if (rel_cnt[n] >= done_dly[n]) begin dn[n] = 1; phase[n] = 4; end
            end
            default: ;
          endcase
        end
        if (PROG_B[n] === 1'b0) begin
          if (prog_run[n] == 0) begin prog_order.push_back(n); prog_fall_cyc[n] = cyc_n; end
          prog_run[n]++;
        end else if (prog_run[n] > 0) begin
          prog_len[n] = prog_run[n]; prog_run[n] = 0;
        end
        if (INIT_B_drv[n] === 1'b1) drv_run[n]++;
        else if (drv_run[n] > 0) begin drv_len[n] = drv_run[n]; drv_run[n] = 0; end
        if (gready_o[n] === 1'b1 && !gready_prev[n]) gready_rise_cyc[n] = cyc_n;
        if (gready_o[n] === 1'b0 &&  gready_prev[n]) gready_fall_cyc[n] = cyc_n;
        gready_prev[n] = (gready_o[n] === 1'b1);
        INIT_B_in[n] = fi[n] & !(INIT_B_drv[n] === 1'b1) & !force_init_low[n];
        dnew = dn[n] & !force_done_low[n];
        if (dnew && !DONE[n]) done_rise_cyc[n] = cyc_n;
        if (!dnew && DONE[n]) done_fall_cyc[n] = cyc_n;
        DONE[n] = dnew;
      end
      if (cyc_n > 2) begin
        if ($countones(~PROG_B) > 1 || $countones(INIT_B_drv) > 1 ||
            ((~PROG_B & ~INIT_B_drv) != 4'h0))
          multi_viol = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic adr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic ack_seen);
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd;
    @(negedge clk_i);
    rd = dat_o; ack_seen = ack_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_wr(input logic adr, input logic [31:0] wd);
    logic [31:0] r; logic a;
    bus_xfer(1'b1, adr, wd, r, a);
  endtask

  task automatic bus_rd(input logic adr, output logic [31:0] rd);
    logic a;
    bus_xfer(1'b0, adr, 32'h0, rd, a);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [31:0] r; int k;
    k = 0;
    do begin bus_rd(1'b0, r); k++; end
    while ((r[8] || r[3:0] != 4'h0) && k < budget);
    check(tag, {31'b0, r[8] | (|r[3:0])}, 32'h0);
  endtask

  task automatic wait_phase(input string tag, input int n, input int ph, input int budget);
    int k;
    k = 0;
    while (phase[n] != ph && k < budget) begin @(negedge clk_i); k++; end
    check(tag, phase[n], ph);
  endtask

  function automatic int order_code(input int q[$]);
    int c = 0;
    foreach (q[i]) c = c * 8 + q[i] + 1;
    return c;
  endfunction

  function automatic int mask_code(input logic [3:0] m);
    int c = 0;
    for (int n = 0; n < 4; n++) if (m[n]) c = c * 8 + n + 1;
    return c;
  endfunction

  initial begin
    logic [31:0] r;
    logic        a;
    logic [3:0]  ready_model, mask;
    int          t;

    // reset state
    repeat (3) @(negedge clk_i);
    check("rst_prog_b", PROG_B, 4'hF);
    check("rst_init_drv", INIT_B_drv, 4'h0);
    check("rst_gready", gready_o, 4'h0);
    check("rst_ack", ack_o, 1'b0);
    check("rst_dat", dat_o, 32'h0);
    rst_n_i = 1'b1;
    bus_xfer(1'b0, 1'b0, 32'h0, r, a);
    check("rst_ctrl", r, 32'h0);
    check("ack_raised", a, 1'b1);
    @(negedge clk_i);
    check("ack_single", ack_o, 1'b0);
    bus_rd(1'b1, r);
    check("rst_status", r[11:0], 12'h0);

    // single GLITC0 sequence with fixed INIT/DONE delays
    init_dly[0] = 5; done_dly[0] = 20;
    prog_order.delete();
    bus_wr(1'b0, 32'h1);
    wait_idle("t1_idle", 100);
    check("t1_prog_len", prog_len[0], PROG_CYCLES);
    check("t1_drv_len", drv_len[0], PROG_CYCLES + INIT_HOLD);
    check("t1_ready_lat", gready_rise_cyc[0] - done_rise_cyc[0], 3);
    check("t1_gready", gready_o, 4'h1);

    // fresh start, two targets in ascending order
    @(negedge clk_i); rst_n_i = 1'b0;
    @(negedge clk_i); rst_n_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      init_dly[n] = $urandom_range(1, 8); done_dly[n] = $urandom_range(1, 30);
    end
    prog_order.delete();
    bus_wr(1'b0, 32'hA);
    wait_idle("t2_idle", 200);
    check("t2_order", order_code(prog_order), mask_code(4'hA));
    check("t2_3_after_1", prog_fall_cyc[3] > gready_rise_cyc[1], 1'b1);
    check("t2_gready", gready_o, 4'hA);
    ready_model = 4'hA;

    // random request masks against the ascending-order / ready-set model
    for (int round = 0; round < 3; round++) begin
      mask = 4'($urandom_range(1, 15));
      for (int n = 0; n < 4; n++) begin
        init_dly[n] = $urandom_range(1, 8); done_dly[n] = $urandom_range(1, 30);
      end
      prog_order.delete();
      bus_wr(1'b0, {28'h0, mask});
      wait_idle($sformatf("rnd%0d_idle", round), 400);
      ready_model = ready_model | mask;
      check($sformatf("rnd%0d_order", round), order_code(prog_order), mask_code(mask));
      check($sformatf("rnd%0d_gready", round), gready_o, ready_model);
    end

    // INIT_B never released: timeout, then clear by STATUS write
    t = $urandom_range(0, 3);
    init_stuck[t] = 1'b1;
    bus_wr(1'b0, 32'h1 << t);
    wait_idle("t3_idle", 100);
    ready_model = ready_model & ~(4'h1 << t);
    bus_rd(1'b1, r);
    check("t3_tmo", r[11:8], 4'h1 << t);
    check("t3_err", r[7:4], 4'h0);
    check("t3_gready", gready_o, ready_model);
    bus_wr(1'b1, 32'hF00);
    bus_rd(1'b1, r);
    check("t3_tmo_clr", r[11:8], 4'h0);
    init_stuck[t] = 1'b0;

    // CRC error on GLITC2 during LOAD
    init_dly[2] = 3; done_dly[2] = 1000;
    bus_wr(1'b0, 32'h4);
    wait_phase("t4_init_up", 2, 3, 100);
    repeat (5) @(negedge clk_i);
    bus_rd(1'b0, r);
    check("t4_in_load", r, 32'h500);
    force_init_low[2] = 1'b1;
    wait_idle("t4_idle", 50);
    ready_model = ready_model & ~4'h4;
    bus_rd(1'b1, r);
    check("t4_err", r[7:4], 4'h4);
    check("t4_gready", gready_o, ready_model);
    force_init_low[2] = 1'b0;
    bus_wr(1'b1, 32'h0F0);
    bus_rd(1'b1, r);
    check("t4_err_clr", r[7:4], 4'h0);

    // ready monitor on GLITC0, then re-arm mid-LOAD and reset
    init_dly[0] = 4; done_dly[0] = 10;
    bus_wr(1'b0, 32'h1);
    wait_idle("t5_idle", 100);
    check("t5_ready", gready_o[0], 1'b1);
    force_done_low[0] = 1'b1;
    repeat (6) @(negedge clk_i);
    check("t5_drop", gready_o[0], 1'b0);
    check("t5_drop_lat", gready_fall_cyc[0] - done_fall_cyc[0], 3);
    bus_rd(1'b1, r);
    check("t5_err", r[7:4], 4'h1);
    force_done_low[0] = 1'b0;
    done_dly[0] = 50;
    bus_wr(1'b0, 32'h1);
    wait_phase("t5_init_up", 0, 3, 100);
    repeat (4) @(negedge clk_i);
    bus_wr(1'b0, 32'h1);
    bus_rd(1'b0, r);
    check("t5_rearm", r, 32'h101);
    @(negedge clk_i); rst_n_i = 1'b0;
    @(negedge clk_i);
    check("t5_rst_prog_b", PROG_B, 4'hF);
    check("t5_rst_init_drv", INIT_B_drv, 4'h0);
    check("t5_rst_gready", gready_o, 4'h0);
    check("t5_rst_ack", ack_o, 1'b0);
    check("t5_rst_dat", dat_o, 32'h0);
    rst_n_i = 1'b1;
    bus_rd(1'b0, r);
    check("t5_rst_ctrl", r, 32'h0);
    bus_rd(1'b1, r);
    check("t5_rst_status", r[11:0], 12'h0);
    repeat (10) @(negedge clk_i);
    check("t5_no_restart", PROG_B, 4'hF);

    check("only_tgt_driven", multi_viol, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
